mmc_call_queue: RTL and testbench

- Upstream feeder for the mmc HLS component.
- Buffers (a, b) argument pairs from a producer using a valid/ready handshake.
- Issues each pair to the component's call interface (start/busy) in order.
- Counts outstanding calls by watching the component's return interface (done/stall), and stops issuing at a credit limit so results are never overrun.

---
 rtl/mmc_call_queue.sv | 104 ++++++++++
 tb/tb_mmc_call_queue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mmc_call_queue.sv
// mmc_call_queue: argument-pair FIFO feeding the mmc component call port,
// with a credit counter on outstanding calls so results are never overrun.
module mmc_call_queue #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              in_a,
  input  logic [DATA_W-1:0]              in_b,
  output logic                           start,
  input  logic                           busy,
  output logic [DATA_W-1:0]              a,
  output logic [DATA_W-1:0]              b,
  input  logic                           ret_done,
  input  logic                           ret_stall,
  output logic [$clog2(DEPTH+1)-1:0]     fill_level,
  output logic [$clog2(MAX_OUT+1)-1:0]   outstanding,
  output logic                           err_underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH+1);
  localparam int OW = $clog2(MAX_OUT+1);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);
  localparam logic [OW-1:0] CMAX = OW'(MAX_OUT);

  logic [DATA_W-1:0] mem_a_q [DEPTH];
  logic [DATA_W-1:0] mem_b_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [OW-1:0]     out_q, out_d;
  logic              err_q, err_d;

  logic push, accept, ret, ret_ok;

  assign in_ready = (fill_q != FULL);
  assign start    = (fill_q != '0) && (out_q != CMAX);
  assign a        = mem_a_q[rd_ptr_q];
  assign b        = mem_b_q[rd_ptr_q];

  assign push   = in_valid && in_ready;
  assign accept = start && !busy;
  assign ret    = ret_done && !ret_stall;
  // A return with nothing outstanding only flags the error.
  assign ret_ok = ret && (out_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    out_d    = out_q;
    err_d    = err_q;
    if (push)
      wr_ptr_d = wr_ptr_q + PW'(1);
    if (accept)
      rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, accept})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase
    unique case ({accept, ret_ok})
      2'b10:   out_d = out_q + OW'(1);
      2'b01:   out_d = out_q - OW'(1);
      default: out_d = out_q;
    endcase
    if (ret && (out_q == '0))
      err_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_a_q[i] <= '0;
        mem_b_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      out_q    <= out_d;
      err_q    <= err_d;
      if (push) begin
        mem_a_q[wr_ptr_q] <= in_a;
        mem_b_q[wr_ptr_q] <= in_b;
      end
    end
  end

  assign fill_level    = fill_q;
  assign outstanding   = out_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_mmc_call_queue.sv
// Directed bench for mmc_call_queue (DEPTH=4, MAX_OUT=2): ordering,
// backpressure, credit limit, return handling, underflow and async reset.
module tb_mmc_call_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic        start, busy;
  logic [31:0] a, b;
  logic        ret_done, ret_stall;
  logic [2:0]  fill_level;
  logic [1:0]  outstanding;
  logic        err_underflow;

  int nvec = 0;
  int nerr = 0;

  mmc_call_queue #(.DATA_W(32), .DEPTH(4), .MAX_OUT(2)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .start(start), .busy(busy),
    .a(a), .b(b),
    .ret_done(ret_done), .ret_stall(ret_stall),
    .fill_level(fill_level), .outstanding(outstanding),
    .err_underflow(err_underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic status(input string tag, input logic [2:0] f,
                        input logic [1:0] o, input logic s);
    chk({tag, ".fill"}, 32'(fill_level), 32'(f));
    chk({tag, ".out"}, 32'(outstanding), 32'(o));
    chk({tag, ".start"}, 32'(start), 32'(s));
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; in_a = 0; in_b = 0;
    busy = 0; ret_done = 0; ret_stall = 0;
    tick(); tick();
    status("rst", 3'd0, 2'd0, 1'b0);
    chk("rst.ready", 32'(in_ready), 32'd1);
    chk("rst.err", 32'(err_underflow), 32'd0);
    chk("rst.a", a, 32'd0);
    chk("rst.b", b, 32'd0);
    reset = 1'b0;
    tick();

    // single pair, one cycle push-to-start latency
    in_valid = 1; in_a = 12; in_b = 18;
    tick();
    in_valid = 0;
    status("t1.push", 3'd1, 2'd0, 1'b1);
    chk("t1.a", a, 32'd12);
    chk("t1.b", b, 32'd18);
    tick();
    status("t1.acc", 3'd0, 2'd1, 1'b0);
    ret_done = 1;
    tick();
    ret_done = 0;
    status("t1.ret", 3'd0, 2'd0, 1'b0);
    chk("t1.err", 32'(err_underflow), 32'd0);

    // fill to DEPTH under busy, fifth pair held off
    busy = 1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; in_a = 100 + i; in_b = 200 + i;
      tick();
    end
    in_a = 105; in_b = 205;
    chk("t2.ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      status("t2.hold", 3'd4, 2'd0, 1'b1);
      chk("t2.hold.a", a, 32'd101);
      chk("t2.hold.b", b, 32'd201);
    end
    busy = 0;
    tick();
    status("t2.rel1", 3'd3, 2'd1, 1'b1);
    chk("t2.rel1.a", a, 32'd102);
    tick();
    in_valid = 0;
    status("t2.rel2", 3'd3, 2'd2, 1'b0);
    chk("t2.rel2.a", a, 32'd103);
    for (int i = 3; i <= 5; i++) begin
      ret_done = 1;
      tick();
      ret_done = 0;
      status("t2.ret", 3'(5 - i + 1), 2'd1, 1'b1);
      chk("t2.ord.a", a, 32'(100 + i));
      chk("t2.ord.b", b, 32'(200 + i));
      tick();
      status("t2.acc", 3'(5 - i), 2'd2, 1'b0);
    end

    // credit limit with three queued
    ret_done = 1;
    tick(); tick();
    ret_done = 0;
    status("t3.drain", 3'd0, 2'd0, 1'b0);
    busy = 1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1; in_a = 300 + i; in_b = 400 + i;
      tick();
    end
    in_valid = 0;
    busy = 0;
    tick();
    status("t3.acc1", 3'd2, 2'd1, 1'b1);
    tick();
    status("t3.acc2", 3'd1, 2'd2, 1'b0);
    tick();
    status("t3.limit", 3'd1, 2'd2, 1'b0);
    ret_done = 1;
    tick();
    ret_done = 0;
    status("t3.ret", 3'd1, 2'd1, 1'b1);
    chk("t3.a", a, 32'd303);
    tick();
    status("t3.acc3", 3'd0, 2'd2, 1'b0);

    // stalled return counts once
    ret_done = 1; ret_stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4.stall", 32'(outstanding), 32'd2);
    end
    ret_stall = 0;
    tick();
    ret_done = 0;
    chk("t4.once", 32'(outstanding), 32'd1);
    in_valid = 1; in_a = 55; in_b = 66;
    tick();
    in_valid = 0;
    status("t4.push", 3'd1, 2'd1, 1'b1);
    ret_done = 1;
    tick();
    ret_done = 0;
    status("t4.accret", 3'd0, 2'd1, 1'b0);

    // underflow
    ret_done = 1;
    tick();
    status("t5.zero", 3'd0, 2'd0, 1'b0);
    chk("t5.noerr", 32'(err_underflow), 32'd0);
    tick();
    ret_done = 0;
    chk("t5.uf.out", 32'(outstanding), 32'd0);
    chk("t5.uf.err", 32'(err_underflow), 32'd1);
    tick(); tick();
    chk("t5.sticky", 32'(err_underflow), 32'd1);
    in_valid = 1; in_a = 77; in_b = 88;
    tick();
    in_valid = 0;
    ret_done = 1;
    tick();
    ret_done = 0;
    status("t5.ufacc", 3'd0, 2'd1, 1'b0);

    // async reset with 3 queued and 2 outstanding
    in_valid = 1; in_a = 1; in_b = 2;
    tick();
    in_valid = 0;
    tick();
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1; in_a = 500 + i; in_b = 600 + i;
      tick();
    end
    in_valid = 0;
    status("t6.pre", 3'd3, 2'd2, 1'b0);
    #2;
    reset = 1;
    #1;
    status("t6.async", 3'd0, 2'd0, 1'b0);
    chk("t6.err", 32'(err_underflow), 32'd0);
    chk("t6.ready", 32'(in_ready), 32'd1);
    chk("t6.a", a, 32'd0);
    #1;
    reset = 0;
    tick();
    in_valid = 1; in_a = 7; in_b = 9;
    tick();
    in_valid = 0;
    status("t6.push", 3'd1, 2'd0, 1'b1);
    chk("t6.new.a", a, 32'd7);
    chk("t6.new.b", b, 32'd9);
    tick();
    status("t6.acc", 3'd0, 2'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
